// File: rtl/vga_pkg.sv
// Shared constants and types for the 1280x1024@60 raster timing generator.
// Default geometry assumes the 108 MHz pixel clock.
package vga_pkg;

    localparam int CW = 11;

    localparam int H_ACTIVE_D = 1280;
    localparam int H_FP_D     = 48;
    localparam int H_SYNC_D   = 112;
    localparam int H_BP_D     = 248;

    localparam int V_ACTIVE_D = 1024;
    localparam int V_FP_D     = 1;
    localparam int V_SYNC_D   = 3;
    localparam int V_BP_D     = 38;

    typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus its ACTIVE/FRONT/SYNC/BACK phase.
// cnt_nxt/phase_nxt describe the position after this edge, so the parent can register aligned outputs.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_D,
    parameter int FP     = H_FP_D,
    parameter int SYNC   = H_SYNC_D,
    parameter int BP     = H_BP_D
) (
    input  logic          VGA_CLK,
    input  logic          reset_n,
    input  logic          step,
    output logic [CW-1:0] cnt_nxt,
    output phase_t        phase_nxt,
    output logic          wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [CW-1:0] LAST_ACT  = CW'(ACTIVE - 1);
    localparam logic [CW-1:0] LAST_FP   = CW'(ACTIVE + FP - 1);
    localparam logic [CW-1:0] LAST_SYNC = CW'(ACTIVE + FP + SYNC - 1);
    localparam logic [CW-1:0] LAST      = CW'(TOTAL - 1);

    generate
        if (TOTAL > (1 << CW)) begin : g_total_chk
            $error("vga_axis_counter: total %0d does not fit in %0d bits", TOTAL, CW);
        end
    endgenerate

    logic [CW-1:0] cnt;
    phase_t        phase;

    assign wrap = step && (cnt == LAST);

    // Phase advances on the last count of each region, so it always matches cnt_nxt.
    always_comb begin
        cnt_nxt   = cnt;
        phase_nxt = phase;
        if (step) begin
            cnt_nxt = wrap ? '0 : cnt + 1'b1;
            case (phase)
                PH_ACTIVE: if (cnt == LAST_ACT)  phase_nxt = PH_FRONT;
                PH_FRONT:  if (cnt == LAST_FP)   phase_nxt = PH_SYNC;
                PH_SYNC:   if (cnt == LAST_SYNC) phase_nxt = PH_BACK;
                PH_BACK:   if (wrap)             phase_nxt = PH_ACTIVE;
            endcase
        end
    end

    // Reset parks on the last position so the first free-running edge wraps to 0.
    always_ff @(posedge VGA_CLK) begin
        if (!reset_n) begin
            cnt   <= LAST;
            phase <= PH_BACK;
        end else begin
            cnt   <= cnt_nxt;
            phase <= phase_nxt;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: pixel coordinates, display enable, syncs and frame start.
// All outputs are registered from next-state counter values, so they share the counters' edge.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_D,
    parameter int   H_FP     = H_FP_D,
    parameter int   H_SYNC   = H_SYNC_D,
    parameter int   H_BP     = H_BP_D,
    parameter int   V_ACTIVE = V_ACTIVE_D,
    parameter int   V_FP     = V_FP_D,
    parameter int   V_SYNC   = V_SYNC_D,
    parameter int   V_BP     = V_BP_D,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic          VGA_CLK,
    input  logic          reset_n,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          disp_en,
    output logic          h_sync,
    output logic          v_sync,
    output logic          frame_start
);

    logic [CW-1:0] h_nxt, v_nxt;
    phase_t        h_ph_nxt, v_ph_nxt;
    logic          h_wrap, v_wrap;
    logic          vis_nxt;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h (
        .VGA_CLK  (VGA_CLK),
        .reset_n  (reset_n),
        .step     (1'b1),
        .cnt_nxt  (h_nxt),
        .phase_nxt(h_ph_nxt),
        .wrap     (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v (
        .VGA_CLK  (VGA_CLK),
        .reset_n  (reset_n),
        .step     (h_wrap),
        .cnt_nxt  (v_nxt),
        .phase_nxt(v_ph_nxt),
        .wrap     (v_wrap)
    );

    assign vis_nxt = (h_ph_nxt == PH_ACTIVE) && (v_ph_nxt == PH_ACTIVE);

    always_ff @(posedge VGA_CLK) begin
        if (!reset_n) begin
            x           <= '0;
            y           <= '0;
            disp_en     <= 1'b0;
            h_sync      <= !HS_POL;
            v_sync      <= !VS_POL;
            frame_start <= 1'b0;
        end else begin
            x           <= vis_nxt ? h_nxt : '0;
            y           <= vis_nxt ? v_nxt : '0;
            disp_en     <= vis_nxt;
            h_sync      <= (h_ph_nxt == PH_SYNC) ? HS_POL : !HS_POL;
            v_sync      <= (v_ph_nxt == PH_SYNC) ? VS_POL : !VS_POL;
            frame_start <= (h_nxt == '0) && (v_nxt == '0);
        end
    end

    // Vertical wrap always coincides with the horizontal wrap that drives it.
    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default-geometry vectors plus small-geometry instances
// compared every cycle against a frame-position reference model.
module tb_vga_timing;

    localparam int S_HA = 4, S_HF = 1, S_HS = 1, S_HB = 1;
    localparam int S_VA = 3, S_VF = 1, S_VS = 1, S_VB = 1;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
    localparam int S_FRAME = S_HT * S_VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d = 1'b0;
    logic rst_s = 1'b0;

    logic [10:0] xd, yd, xp, yp, xn, yn;
    logic        ded, hsd, vsd, fsd;
    logic        dep, hsp, vsp, fsp;
    logic        den, hsn, vsn, fsn;

    vga_timing u_dflt (
        .VGA_CLK(clk), .reset_n(rst_d), .x(xd), .y(yd),
        .disp_en(ded), .h_sync(hsd), .v_sync(vsd), .frame_start(fsd)
    );

    vga_timing #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_spos (
        .VGA_CLK(clk), .reset_n(rst_s), .x(xp), .y(yp),
        .disp_en(dep), .h_sync(hsp), .v_sync(vsp), .frame_start(fsp)
    );

    vga_timing #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_sneg (
        .VGA_CLK(clk), .reset_n(rst_s), .x(xn), .y(yn),
        .disp_en(den), .h_sync(hsn), .v_sync(vsn), .frame_start(fsn)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: small instances are described by one linear frame position.
    int p_s   = 0;
    bit s_rst = 1'b1;
    bit chk_s = 1'b0;

    typedef struct {
        int          k;
        logic [10:0] x;
        logic [10:0] y;
        logic        de, hs, vs, fs;
    } vec_t;

    task automatic chk(input string name, input logic [25:0] act, input logic [25:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got x=%0d y=%0d de/hs/vs/fs=%b expected x=%0d y=%0d de/hs/vs/fs=%b",
                     name, $time, act[25:15], act[14:4], act[3:0], exp[25:15], exp[14:4], exp[3:0]);
        end
    endtask

    function automatic logic [25:0] sexp(input logic pol);
        int h, v;
        logic de, hs, vs;
        if (s_rst) return {22'd0, 1'b0, !pol, !pol, 1'b0};
        h  = p_s % S_HT;
        v  = p_s / S_HT;
        de = (h < S_HA) && (v < S_VA);
        hs = (h >= S_HA + S_HF && h < S_HA + S_HF + S_HS) ? pol : !pol;
        vs = (v >= S_VA + S_VF && v < S_VA + S_VF + S_VS) ? pol : !pol;
        return {de ? 11'(h) : 11'd0, de ? 11'(v) : 11'd0, de, hs, vs, p_s == 0};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_s) begin
            p_s   = S_FRAME - 1;
            s_rst = 1'b1;
        end else begin
            p_s   = (p_s + 1) % S_FRAME;
            s_rst = 1'b0;
        end
        #1;
        if (chk_s) begin
            chk("small_pos", {xp, yp, dep, hsp, vsp, fsp}, sexp(1'b1));
            chk("small_neg", {xn, yn, den, hsn, vsn, fsn}, sexp(1'b0));
        end
    endtask

    initial begin
        vec_t tbl[11];
        int   k;
        int   de_n, hs_n, hs_first, bad;
        int   fs_at[$];

        // Edge k after release shows pixel h=(k-1)%1688 of line (k-1)/1688.
        tbl = '{
            '{1,    11'd0,    11'd0, 1'b1, 1'b0, 1'b0, 1'b1},
            '{2,    11'd1,    11'd0, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1280, 11'd1279, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1281, 11'd0,    11'd0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1328, 11'd0,    11'd0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1329, 11'd0,    11'd0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{1440, 11'd0,    11'd0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{1441, 11'd0,    11'd0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1688, 11'd0,    11'd0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1689, 11'd0,    11'd1, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1690, 11'd1,    11'd1, 1'b1, 1'b0, 1'b0, 1'b0}
        };

        // Default geometry: reset hold, then first-line vectors.
        repeat (5) begin
            tick();
            chk("dflt_reset", {xd, yd, ded, hsd, vsd, fsd}, 26'd0);
        end
        rst_d = 1'b1;
        k = 0;
        foreach (tbl[i]) begin
            while (k < tbl[i].k) begin
                tick();
                k++;
            end
            chk($sformatf("dflt_vec%0d", tbl[i].k), {xd, yd, ded, hsd, vsd, fsd},
                {tbl[i].x, tbl[i].y, tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].fs});
        end

        // Scan line 2 in full.
        while (k < 2 * 1688) begin
            tick();
            k++;
        end
        de_n = 0; hs_n = 0; hs_first = -1; bad = 0;
        for (int i = 0; i < 1688; i++) begin
            tick();
            k++;
            if (ded) begin
                de_n++;
                if (xd != 11'(i) || yd != 11'd2) bad++;
            end else if (xd != 11'd0 || yd != 11'd0) begin
                bad++;
            end
            if (ded != (i < 1280)) bad++;
            if (hsd) begin
                hs_n++;
                if (hs_first < 0) hs_first = i;
            end
            if (vsd || fsd) bad++;
        end
        chk("line_de_count", 26'(de_n), 26'd1280);
        chk("line_hs_count", 26'(hs_n), 26'd112);
        chk("line_hs_first", 26'(hs_first), 26'd1328);
        chk("line_pixel_errs", 26'(bad), 26'd0);

        // Mid-frame reset for one cycle.
        repeat (641) begin
            tick();
            k++;
        end
        chk("pre_reset_pixel", {xd, yd, ded, hsd, vsd, fsd}, {11'd640, 11'd3, 4'b1000});
        rst_d = 1'b0;
        tick();
        chk("mid_reset", {xd, yd, ded, hsd, vsd, fsd}, 26'd0);
        rst_d = 1'b1;
        tick();
        chk("post_reset_start", {xd, yd, ded, hsd, vsd, fsd}, {11'd0, 11'd0, 4'b1001});

        // Small geometry: reset, then two exhaustive frames.
        chk_s = 1'b1;
        repeat (3) tick();
        rst_s = 1'b1;
        for (int j = 1; j <= 2 * S_FRAME; j++) begin
            tick();
            if (fsp) fs_at.push_back(j);
        end
        chk("small_fs_count", 26'(fs_at.size()), 26'd2);
        if (fs_at.size() == 2) begin
            chk("small_fs_first", 26'(fs_at[0]), 26'd1);
            chk("small_fs_period", 26'(fs_at[1] - fs_at[0]), 26'(S_FRAME));
        end

        // Randomly placed resets against the model.
        for (int j = 0; j < 1500; j++) begin
            rst_s = ($urandom_range(0, 24) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
